// File: rtl/lc3b_types.sv
// Shared LC-3b word/cacheline types and pmem line-address helpers.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  // Byte offset within a 16-byte cacheline.
  localparam int unsigned PMEM_LINE_OFFSET_BITS = 4;

  // Line address: the byte address with the in-line offset removed.
  typedef logic [15-PMEM_LINE_OFFSET_BITS:0] pmem_line_addr_t;

  function automatic pmem_line_addr_t pmem_line_addr(input lc3b_word addr);
    return addr[15:PMEM_LINE_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/pmem_line_array.sv
// Line storage for the pmem responder: 2^INDEX_BITS x 128b data, per-line valid
// bits (async-cleared), one write port and a registered read port that returns
// zero for lines never written since reset.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] waddr,
  input  lc3b_cacheline         wdata,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] raddr,
  output lc3b_cacheline         rdata
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  lc3b_cacheline   mem [LINES];
  logic [LINES-1:0] valid;

  // Data storage is deliberately not reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Valid bits: cleared asynchronously, set on each line write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  valid <= '0;
    else if (we)   valid[waddr] <= 1'b1;
  end

  // Registered read; an invalid line reads back as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= valid[raddr] ? mem[raddr] : '0;
  end

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder for the pmem_* cacheline interface: accepts one line
// read or write, holds it for LATENCY cycles, pulses pmem_resp, then spends one
// recovery cycle before accepting again. Protocol violations set a sticky err.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pmem_read,
  input  logic          pmem_write,
  input  lc3b_word      pmem_address,
  input  lc3b_cacheline pmem_wdata,
  output logic          pmem_resp,
  output lc3b_cacheline pmem_rdata,
  output logic          busy,
  output logic          err
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP,
    ST_RECOVER
  } state_t;

  state_t          state, state_next;
  logic [CNT_W-1:0] count;

  // Latched transaction
  logic            op_write;
  logic            req_rd_q;
  logic            req_wr_q;
  pmem_line_addr_t line_q;
  lc3b_cacheline   wdata_q;

  lc3b_cacheline   rdata_hold;
  lc3b_cacheline   array_rdata;

  logic            accept;
  logic            commit;
  logic            proto_err;
  logic            req_mismatch;

  // Offset bits within the line carry no information for a line transfer.
  logic            unused_offset_bits;
  assign unused_offset_bits = ^pmem_address[PMEM_LINE_OFFSET_BITS-1:0];

  // Any deviation from the latched request while it is in flight.
  assign req_mismatch = (pmem_line_addr(pmem_address) != line_q) ||
                        (pmem_read  != req_rd_q) ||
                        (pmem_write != req_wr_q) ||
                        !(pmem_read || pmem_write);

  // Next-state decode and per-state outputs.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    proto_err  = 1'b0;
    pmem_resp  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pmem_read || pmem_write) begin
          accept     = 1'b1;
          proto_err  = pmem_read && pmem_write;
          state_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy      = 1'b1;
        proto_err = req_mismatch;
        if (count == CNT_W'(1)) state_next = ST_RESP;
      end
      ST_RESP: begin
        busy       = 1'b1;
        pmem_resp  = 1'b1;
        proto_err  = req_mismatch;
        commit     = op_write;
        state_next = ST_RECOVER;
      end
      ST_RECOVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Latency counter, latched request and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      op_write <= 1'b0;
      req_rd_q <= 1'b0;
      req_wr_q <= 1'b0;
      line_q   <= '0;
      wdata_q  <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        count    <= CNT_W'(LATENCY - 1);
        op_write <= pmem_write;
        req_rd_q <= pmem_read;
        req_wr_q <= pmem_write;
        line_q   <= pmem_line_addr(pmem_address);
        wdata_q  <= pmem_wdata;
      end else if (state == ST_BUSY) begin
        count <= count - CNT_W'(1);
      end
      if (proto_err) err <= 1'b1;
    end
  end

  // Array lookup is issued at acceptance so the data is ready even when
  // LATENCY is 1; the output mux below only exposes it in a read RESP cycle,
  // and the hold register takes it at the edge ending that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              rdata_hold <= '0;
    else if ((state == ST_RESP) && !op_write)  rdata_hold <= array_rdata;
  end

  assign pmem_rdata = ((state == ST_RESP) && !op_write) ? array_rdata : rdata_hold;

  pmem_line_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (commit),
    .waddr   (line_q[INDEX_BITS-1:0]),
    .wdata   (wdata_q),
    .re      (accept),
    .raddr   (pmem_address[INDEX_BITS+PMEM_LINE_OFFSET_BITS-1:PMEM_LINE_OFFSET_BITS]),
    .rdata   (array_rdata)
  );

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: two instances (LATENCY 4 and 1),
// expected responses queued at issue and compared when pmem_resp is seen.
module tb_pmem_responder;
  import lc3b_types::*;

  localparam int unsigned LAT0  = 4;
  localparam int unsigned LAT1  = 1;
  localparam int unsigned LIMIT = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [1:0]    rd, wr;
  lc3b_word      addr0, addr1;
  lc3b_cacheline wdata0, wdata1;
  logic          resp0, resp1, busy0, busy1, err0, err1;
  lc3b_cacheline rdata0, rdata1;

  pmem_responder #(.LATENCY(LAT0), .INDEX_BITS(6)) dut0 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr0), .pmem_wdata(wdata0), .pmem_resp(resp0),
    .pmem_rdata(rdata0), .busy(busy0), .err(err0));

  pmem_responder #(.LATENCY(LAT1), .INDEX_BITS(6)) dut1 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_resp(resp1),
    .pmem_rdata(rdata1), .busy(busy1), .err(err1));

  typedef struct {
    int unsigned   dut;
    logic          is_read;
    lc3b_cacheline data;
  } exp_t;

  exp_t          sb[$];
  lc3b_cacheline mdl[int unsigned];
  lc3b_cacheline last_rd[2];
  logic          exp_err[2];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic resp_of(input int unsigned d);
    return (d == 0) ? resp0 : resp1;
  endfunction
  function automatic logic busy_of(input int unsigned d);
    return (d == 0) ? busy0 : busy1;
  endfunction
  function automatic logic err_of(input int unsigned d);
    return (d == 0) ? err0 : err1;
  endfunction
  function automatic lc3b_cacheline rdata_of(input int unsigned d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  task automatic set_addr(input int unsigned d, input lc3b_word a);
    if (d == 0) addr0 = a; else addr1 = a;
  endtask

  // One complete transaction; optionally moves the address while in BUSY.
  task automatic txn(input int unsigned d, input logic r, input logic w,
                     input lc3b_word a, input lc3b_cacheline wd,
                     input logic mid_change, input lc3b_word a2);
    exp_t        e;
    int unsigned cyc;
    int unsigned lat;
    logic        got;
    int unsigned key;
    key       = d * 1024 + int'(a[9:4]);
    e.dut     = d;
    e.is_read = r && !w;
    if (w)                    e.data = last_rd[d];
    else if (mdl.exists(key)) e.data = mdl[key];
    else                      e.data = '0;
    sb.push_back(e);

    @(posedge clk); #1;
    rd[d] = r;
    wr[d] = w;
    set_addr(d, a);
    if (d == 0) wdata0 = wd; else wdata1 = wd;
    if (r && w)     exp_err[d] = 1'b1;
    if (mid_change) exp_err[d] = 1'b1;

    got = 1'b0;
    cyc = 0;
    while (!got && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
      if (mid_change && cyc == 1) set_addr(d, a2);
      got = resp_of(d);
    end
    lat = (d == 0) ? LAT0 : LAT1;
    check("resp_latency", 128'(cyc), 128'(lat));

    e = sb.pop_front();
    if (got) begin
      check("rdata", rdata_of(e.dut), e.data);
      check("busy_in_resp", 128'(busy_of(d)), 128'(1'b1));
      check("err", 128'(err_of(d)), 128'(exp_err[d]));
      if (e.is_read) last_rd[d] = e.data;
      @(posedge clk); #1;
      check("resp_single_pulse", 128'(resp_of(d)), 128'(1'b0));
      check("rdata_held", rdata_of(d), last_rd[d]);
      if (w) mdl[key] = wd;
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  lc3b_cacheline d_beef, d_a, d_b, d_c, d_al0, d_al1, rnd;
  lc3b_word      ra;

  initial begin
    d_beef = {8{16'hBEEF}};
    d_a    = {4{32'h1111_2222}};
    d_b    = {4{32'h3333_4444}};
    d_c    = {4{32'hCAFE_0100}};
    d_al0  = {2{64'h0123_4567_89AB_CDEF}};
    d_al1  = {2{64'hFEDC_BA98_7654_3210}};
    reset_n = 1'b0;
    rd = '0; wr = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;

    // Reset state
    #12;
    check("rst_resp", 128'({resp0, resp1}), 128'(2'b00));
    check("rst_busy", 128'({busy0, busy1}), 128'(2'b00));
    check("rst_err",  128'({err0, err1}),   128'(2'b00));
    check("rst_rdata", rdata0 | rdata1, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Unwritten line reads zero at full latency
    txn(0, 1'b1, 1'b0, 16'h0040, '0, 1'b0, '0);
    // Write then read back
    txn(0, 1'b0, 1'b1, 16'h1230, d_beef, 1'b0, '0);
    txn(0, 1'b1, 1'b0, 16'h1230, '0, 1'b0, '0);
    // Read and write together: write wins, err sticks
    txn(0, 1'b1, 1'b1, 16'h0100, d_c, 1'b0, '0);
    txn(0, 1'b1, 1'b0, 16'h0100, '0, 1'b0, '0);
    // Address moved during BUSY: latched line still served
    txn(0, 1'b0, 1'b1, 16'h0200, d_a, 1'b0, '0);
    txn(0, 1'b0, 1'b1, 16'h0210, d_b, 1'b0, '0);
    txn(0, 1'b1, 1'b0, 16'h0200, '0, 1'b1, 16'h0210);
    // Aliasing above INDEX_BITS, both latencies
    txn(0, 1'b0, 1'b1, 16'h0010, d_al0, 1'b0, '0);
    txn(0, 1'b1, 1'b0, 16'h0410, '0, 1'b0, '0);
    txn(1, 1'b0, 1'b1, 16'h0010, d_al1, 1'b0, '0);
    txn(1, 1'b1, 1'b0, 16'h0410, '0, 1'b0, '0);
    txn(1, 1'b1, 1'b0, 16'h0020, '0, 1'b0, '0);

    // Mixed random traffic on the LATENCY=4 instance
    for (int i = 0; i < 16; i++) begin
      ra  = 16'($urandom) & 16'hFFF0;
      rnd = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0) txn(0, 1'b0, 1'b1, ra, rnd, 1'b0, '0);
      else                           txn(0, 1'b1, 1'b0, ra, '0, 1'b0, '0);
    end
    txn(0, 1'b1, 1'b0, 16'h1230, '0, 1'b0, '0);

    // Reset mid-BUSY aborts a pending write
    @(posedge clk); #1;
    wr[0] = 1'b1; addr0 = 16'h0300; wdata0 = d_beef;
    @(posedge clk); #1;
    check("busy_after_accept", 128'(busy0), 128'(1'b1));
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("abort_resp",  128'(resp0), 128'(1'b0));
    check("abort_busy",  128'(busy0), 128'(1'b0));
    check("abort_err",   128'(err0),  128'(1'b0));
    check("abort_rdata", rdata0, '0);
    wr[0] = 1'b0;
    mdl.delete();
    last_rd[0] = '0; last_rd[1] = '0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    txn(0, 1'b1, 1'b0, 16'h0300, '0, 1'b0, '0);
    txn(0, 1'b1, 1'b0, 16'h1230, '0, 1'b0, '0);
    txn(1, 1'b1, 1'b0, 16'h0410, '0, 1'b0, '0);

    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
